// File: rtl/pll_mon_pkg.sv
// Shared types and helpers for the PLL lock monitor: FSM state encoding and
// the window balance metric.
package pll_mon_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } mon_state_t;

    function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/pll_mon_chan.sv
// One PFD/charge-pump channel: window up/down tallies, lock FSM, overlap run
// tracking and sticky error flags with a saturating event counter.
module pll_mon_chan
    import pll_mon_pkg::*;
#(
    parameter int WINDOW      = 64,
    parameter int TOL         = 2,
    parameter int LOCK_WINS   = 4,
    parameter int MAX_OVERLAP = 3,
    parameter int CODE_W      = 10,
    parameter int CODE_LO     = 31,
    parameter int CODE_HI     = 992,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                 refclk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 clr_err,
    input  logic                 win_end,
    input  logic                 d,
    input  logic                 up,
    input  logic                 down,
    input  logic [CODE_W-1:0]    cp_code,
    output logic                 locked,
    output logic                 lock_lost,
    output logic                 err_d,
    output logic                 err_range,
    output logic                 err_overlap,
    output logic                 err_xz,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int CNT_W = $clog2(WINDOW + 1);
    localparam int RUN_W = $clog2(MAX_OVERLAP + 2);
    localparam int GW_W  = $clog2(LOCK_WINS + 1);
    localparam logic [CODE_W-1:0] LO_CODE = CODE_W'(CODE_LO);
    localparam logic [CODE_W-1:0] HI_CODE = CODE_W'(CODE_HI);
    localparam logic [31:0]       TOL_U   = 32'(TOL);

    logic                 up_v, down_v, both;
    logic                 cond_d, cond_range, cond_ovl, cond_xz, any_cond;
    logic [CNT_W-1:0]     up_tot, down_tot;
    logic [CNT_W-1:0]     up_cnt_q, up_cnt_d, down_cnt_q, down_cnt_d;
    logic [RUN_W-1:0]     run_q, run_d;
    logic                 ovl_win_q, ovl_win_d, good_win;
    mon_state_t           state_q, state_d;
    logic [GW_W-1:0]      good_wins_q, good_wins_d;
    logic                 locked_q, locked_d, lock_lost_q, lock_lost_d;
    logic                 flag_d_q, flag_d_d, flag_range_q, flag_range_d;
    logic                 flag_ovl_q, flag_ovl_d, flag_xz_q, flag_xz_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        // Unknown PFD bits never count toward the window tallies
        up_v   = $isunknown(up)   ? 1'b0 : up;
        down_v = $isunknown(down) ? 1'b0 : down;
        both   = up_v & down_v;

        cond_xz    = en && $isunknown({d, up, down, cp_code});
        cond_d     = en && !$isunknown(d) && !d;
        cond_range = en && !$isunknown(cp_code) && ((cp_code < LO_CODE) || (cp_code > HI_CODE));
        cond_ovl   = en && both && (run_q >= RUN_W'(MAX_OVERLAP));
        any_cond   = cond_d | cond_range | cond_ovl | cond_xz;

        run_d = '0;
        if (en && both) begin
            run_d = (run_q > RUN_W'(MAX_OVERLAP)) ? run_q : run_q + RUN_W'(1);
        end

        up_tot     = up_cnt_q + CNT_W'(up_v);
        down_tot   = down_cnt_q + CNT_W'(down_v);
        up_cnt_d   = (!en || win_end) ? '0 : up_tot;
        down_cnt_d = (!en || win_end) ? '0 : down_tot;
        ovl_win_d  = (!en || win_end) ? 1'b0 : (ovl_win_q | cond_ovl);
        good_win   = (abs_diff(32'(up_tot), 32'(down_tot)) <= TOL_U) && !(ovl_win_q || cond_ovl);

        state_d     = state_q;
        good_wins_d = good_wins_q;
        lock_lost_d = 1'b0;
        if (!en) begin
            state_d     = IDLE;
            good_wins_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d     = ACQ;
                    good_wins_d = '0;
                end
                ACQ: begin
                    if (win_end) begin
                        if (!good_win) begin
                            good_wins_d = '0;
                        end else if (good_wins_q == GW_W'(LOCK_WINS - 1)) begin
                            good_wins_d = GW_W'(LOCK_WINS);
                            state_d     = LOCKED;
                        end else begin
                            good_wins_d = good_wins_q + GW_W'(1);
                        end
                    end
                end
                LOCKED: begin
                    if (win_end && !good_win) begin
                        state_d     = ACQ;
                        good_wins_d = '0;
                        lock_lost_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        locked_d = (state_d == LOCKED);

        // A condition in the clearing cycle survives the clear
        if (clr_err) begin
            flag_d_d     = cond_d;
            flag_range_d = cond_range;
            flag_ovl_d   = cond_ovl;
            flag_xz_d    = cond_xz;
            err_cnt_d    = any_cond ? ERR_CNT_W'(1) : '0;
        end else begin
            flag_d_d     = flag_d_q | cond_d;
            flag_range_d = flag_range_q | cond_range;
            flag_ovl_d   = flag_ovl_q | cond_ovl;
            flag_xz_d    = flag_xz_q | cond_xz;
            err_cnt_d    = err_cnt_q;
            if (any_cond && (err_cnt_q != '1)) begin
                err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            up_cnt_q     <= '0;
            down_cnt_q   <= '0;
            run_q        <= '0;
            ovl_win_q    <= 1'b0;
            state_q      <= IDLE;
            good_wins_q  <= '0;
            locked_q     <= 1'b0;
            lock_lost_q  <= 1'b0;
            flag_d_q     <= 1'b0;
            flag_range_q <= 1'b0;
            flag_ovl_q   <= 1'b0;
            flag_xz_q    <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            up_cnt_q     <= up_cnt_d;
            down_cnt_q   <= down_cnt_d;
            run_q        <= run_d;
            ovl_win_q    <= ovl_win_d;
            state_q      <= state_d;
            good_wins_q  <= good_wins_d;
            locked_q     <= locked_d;
            lock_lost_q  <= lock_lost_d;
            flag_d_q     <= flag_d_d;
            flag_range_q <= flag_range_d;
            flag_ovl_q   <= flag_ovl_d;
            flag_xz_q    <= flag_xz_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign locked      = locked_q;
    assign lock_lost   = lock_lost_q;
    assign err_d       = flag_d_q;
    assign err_range   = flag_range_q;
    assign err_overlap = flag_ovl_q;
    assign err_xz      = flag_xz_q;
    assign err_cnt     = err_cnt_q;

endmodule

// File: rtl/pll_lock_monitor.sv
// N-channel PLL lock and health monitor on refclk; owns the shared
// observation window counter and one pll_mon_chan per channel.
module pll_lock_monitor
    import pll_mon_pkg::*;
#(
    parameter int N_CH        = 1,
    parameter int WINDOW      = 64,
    parameter int TOL         = 2,
    parameter int LOCK_WINS   = 4,
    parameter int MAX_OVERLAP = 3,
    parameter int CODE_W      = 10,
    parameter int CODE_LO     = 31,
    parameter int CODE_HI     = 992,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                      refclk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      clr_err,
    input  logic [N_CH-1:0]           d,
    input  logic [N_CH-1:0]           up,
    input  logic [N_CH-1:0]           down,
    input  logic [N_CH*CODE_W-1:0]    cp_code,
    output logic [N_CH-1:0]           locked,
    output logic [N_CH-1:0]           lock_lost,
    output logic [N_CH-1:0]           err_d,
    output logic [N_CH-1:0]           err_range,
    output logic [N_CH-1:0]           err_overlap,
    output logic [N_CH-1:0]           err_xz,
    output logic [N_CH*ERR_CNT_W-1:0] err_cnt
);

    localparam int WIN_W = $clog2(WINDOW);

    logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
    logic             win_end;

    always_comb begin
        win_end   = en && (win_cnt_q == WIN_W'(WINDOW - 1));
        win_cnt_d = '0;
        if (en && !win_end) begin
            win_cnt_d = win_cnt_q + WIN_W'(1);
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            win_cnt_q <= '0;
        end else begin
            win_cnt_q <= win_cnt_d;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        pll_mon_chan #(
            .WINDOW      (WINDOW),
            .TOL         (TOL),
            .LOCK_WINS   (LOCK_WINS),
            .MAX_OVERLAP (MAX_OVERLAP),
            .CODE_W      (CODE_W),
            .CODE_LO     (CODE_LO),
            .CODE_HI     (CODE_HI),
            .ERR_CNT_W   (ERR_CNT_W)
        ) u_chan (
            .refclk      (refclk),
            .rst         (rst),
            .en          (en),
            .clr_err     (clr_err),
            .win_end     (win_end),
            .d           (d[i]),
            .up          (up[i]),
            .down        (down[i]),
            .cp_code     (cp_code[i*CODE_W +: CODE_W]),
            .locked      (locked[i]),
            .lock_lost   (lock_lost[i]),
            .err_d       (err_d[i]),
            .err_range   (err_range[i]),
            .err_overlap (err_overlap[i]),
            .err_xz      (err_xz[i]),
            .err_cnt     (err_cnt[i*ERR_CNT_W +: ERR_CNT_W])
        );
    end

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Bench for pll_lock_monitor (two channels): directed scenarios plus random
// traffic, compared each cycle against a window-level behavioural model.
module tb_pll_lock_monitor;

    localparam int N       = 2;
    localparam int WINDOW  = 64;
    localparam int TOL     = 2;
    localparam int LWINS   = 4;
    localparam int MAX_OVL = 3;
    localparam int CODE_W  = 10;
    localparam int CODE_LO = 31;
    localparam int CODE_HI = 992;
    localparam int ECW     = 8;
    localparam int CNT_MAX = (1 << ECW) - 1;

    localparam int M_BAL = 0, M_IMB = 1, M_OV3 = 2, M_OV4 = 3, M_RND = 4;

    logic                refclk = 1'b0;
    logic                rst, en, clr_err;
    logic [N-1:0]        d, up, down;
    logic [N*CODE_W-1:0] cp_code;
    logic [N-1:0]        locked, lock_lost, err_d, err_range, err_overlap, err_xz;
    logic [N*ECW-1:0]    err_cnt;

    int checks = 0;
    int errors = 0;

    always #5 refclk = ~refclk;

    pll_lock_monitor #(
        .N_CH(N), .WINDOW(WINDOW), .TOL(TOL), .LOCK_WINS(LWINS), .MAX_OVERLAP(MAX_OVL),
        .CODE_W(CODE_W), .CODE_LO(CODE_LO), .CODE_HI(CODE_HI), .ERR_CNT_W(ECW)
    ) dut (
        .refclk(refclk), .rst(rst), .en(en), .clr_err(clr_err),
        .d(d), .up(up), .down(down), .cp_code(cp_code),
        .locked(locked), .lock_lost(lock_lost), .err_d(err_d), .err_range(err_range),
        .err_overlap(err_overlap), .err_xz(err_xz), .err_cnt(err_cnt)
    );

    // Reference model state
    int m_pos;
    int m_up[N], m_dn[N], m_run[N], m_streak[N], m_cnt[N];
    bit m_ovl[N], m_locked[N], m_lost[N], m_fd[N], m_fr[N], m_fo[N], m_fx[N];
    int mode[N], ph_u[N], ph_d[N];

    task automatic model_reset();
        m_pos = 0;
        for (int c = 0; c < N; c++) begin
            m_up[c] = 0; m_dn[c] = 0; m_run[c] = 0; m_streak[c] = 0; m_cnt[c] = 0;
            m_ovl[c] = 0; m_locked[c] = 0; m_lost[c] = 0;
            m_fd[c] = 0; m_fr[c] = 0; m_fo[c] = 0; m_fx[c] = 0;
        end
    endtask

    task automatic model_edge();
        if (rst === 1'b1) return;
        for (int c = 0; c < N; c++) begin
            logic [CODE_W-1:0] code;
            bit u, dn, fd, fr, fo, fx, any, good;
            int diff;
            code = cp_code[c*CODE_W +: CODE_W];
            u  = (up[c] === 1'b1);
            dn = (down[c] === 1'b1);
            fd = 0; fr = 0; fo = 0; fx = 0;
            if (en === 1'b1) begin
                fx = $isunknown({d[c], up[c], down[c], code});
                fd = (d[c] === 1'b0);
                fr = !$isunknown(code) && ((int'(code) < CODE_LO) || (int'(code) > CODE_HI));
                m_run[c] = (u && dn) ? m_run[c] + 1 : 0;
                fo = (m_run[c] > MAX_OVL);
            end else begin
                m_run[c] = 0;
            end
            any = fd | fr | fo | fx;
            if (clr_err === 1'b1) begin
                m_fd[c] = fd; m_fr[c] = fr; m_fo[c] = fo; m_fx[c] = fx;
                m_cnt[c] = any ? 1 : 0;
            end else begin
                m_fd[c] |= fd; m_fr[c] |= fr; m_fo[c] |= fo; m_fx[c] |= fx;
                if (any && m_cnt[c] < CNT_MAX) m_cnt[c]++;
            end
            m_lost[c] = 0;
            if (en !== 1'b1) begin
                m_up[c] = 0; m_dn[c] = 0; m_ovl[c] = 0; m_locked[c] = 0; m_streak[c] = 0;
            end else begin
                m_up[c] += int'(u);
                m_dn[c] += int'(dn);
                m_ovl[c] |= fo;
                if (m_pos == WINDOW - 1) begin
                    diff = (m_up[c] > m_dn[c]) ? m_up[c] - m_dn[c] : m_dn[c] - m_up[c];
                    good = (diff <= TOL) && !m_ovl[c];
                    if (good) begin
                        m_streak[c]++;
                        if (m_streak[c] >= LWINS) m_locked[c] = 1;
                    end else begin
                        if (m_locked[c]) m_lost[c] = 1;
                        m_locked[c] = 0;
                        m_streak[c] = 0;
                    end
                    m_up[c] = 0; m_dn[c] = 0; m_ovl[c] = 0;
                end
            end
        end
        if (en !== 1'b1) m_pos = 0;
        else m_pos = (m_pos == WINDOW - 1) ? 0 : m_pos + 1;
    endtask

    task automatic chk(input string tag, input int ch, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s ch%0d: observed %0h expected %0h", tag, ch, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int c = 0; c < N; c++) begin
            chk("locked", c, 32'(locked[c]), 32'(m_locked[c]));
            chk("lock_lost", c, 32'(lock_lost[c]), 32'(m_lost[c]));
            chk("err_d", c, 32'(err_d[c]), 32'(m_fd[c]));
            chk("err_range", c, 32'(err_range[c]), 32'(m_fr[c]));
            chk("err_overlap", c, 32'(err_overlap[c]), 32'(m_fo[c]));
            chk("err_xz", c, 32'(err_xz[c]), 32'(m_fx[c]));
            chk("err_cnt", c, 32'(err_cnt[c*ECW +: ECW]), 32'(m_cnt[c]));
        end
    endtask

    task automatic set_code(input int c, input int v);
        cp_code[c*CODE_W +: CODE_W] = CODE_W'(v);
    endtask

    task automatic drive();
        for (int c = 0; c < N; c++) begin
            bit bu, bd, burst;
            bu = ((m_pos % 8) == ph_u[c]);
            bd = ((m_pos % 8) == ph_d[c]);
            burst = 0;
            case (mode[c])
                M_IMB: begin bu = (m_pos < 10); bd = (m_pos >= 20 && m_pos < 22); end
                M_OV3: burst = (m_pos >= 10 && m_pos < 13);
                M_OV4: burst = (m_pos >= 10 && m_pos < 14);
                M_RND: begin bu = ($urandom_range(0, 3) == 0); bd = ($urandom_range(0, 3) == 0); end
                default: ;
            endcase
            up[c]   = bu | burst;
            down[c] = bd | burst;
        end
    endtask

    task automatic step();
        drive();
        @(posedge refclk);
        model_edge();
        @(negedge refclk);
        check_all();
    endtask

    task automatic new_phases();
        for (int c = 0; c < N; c++) begin
            ph_u[c] = $urandom_range(0, 7);
            ph_d[c] = (ph_u[c] + $urandom_range(1, 7)) % 8;
            mode[c] = M_BAL;
        end
    endtask

    initial begin
        logic xprobe;
        bit   sim4;
        xprobe = 1'bx;
        sim4 = $isunknown(xprobe);

        rst = 1'b1; en = 1'b0; clr_err = 1'b0;
        d = '1; up = '0; down = '0; cp_code = '0;
        for (int c = 0; c < N; c++) set_code(c, 512);
        new_phases();
        model_reset();
        #1;
        check_all();
        @(negedge refclk); @(negedge refclk);
        check_all();
        rst = 1'b0;

        // Balanced lock: locked rises on edge 256
        en = 1'b1;
        for (int i = 0; i < 256; i++) begin
            for (int c = 0; c < N; c++) set_code(c, $urandom_range(CODE_LO, CODE_HI));
            step();
            if (i == 254) chk("lock_edge255", 0, 32'(locked), 32'(0));
        end
        chk("lock_edge256", 0, 32'(locked), 32'(2'b11));
        chk("bal_errcnt", 0, 32'(err_cnt), 32'(0));
        chk("bal_flags", 0, 32'({err_d, err_range, err_overlap, err_xz}), 32'(0));

        // Imbalance on channel 0, then relock
        for (int c = 0; c < N; c++) set_code(c, 512);
        mode[0] = M_IMB;
        for (int i = 0; i < WINDOW; i++) step();
        chk("imb_locked", 0, 32'(locked), 32'(2'b10));
        chk("imb_lost", 0, 32'(lock_lost), 32'(2'b01));
        mode[0] = M_BAL;
        for (int i = 0; i < 4 * WINDOW; i++) begin
            step();
            if (i == 0) chk("lost_pulse_end", 0, 32'(lock_lost[0]), 32'(0));
            if (i == 4 * WINDOW - 2) chk("relock_early", 0, 32'(locked[0]), 32'(0));
        end
        chk("relock", 0, 32'(locked[0]), 32'(1));

        // Overlap boundary: a 3-cycle run is legal, a 4-cycle run is not
        mode[0] = M_OV3;
        for (int i = 0; i < WINDOW; i++) step();
        chk("ovl3_flag", 0, 32'(err_overlap[0]), 32'(0));
        chk("ovl3_cnt", 0, 32'(err_cnt[0 +: ECW]), 32'(0));
        chk("ovl3_locked", 0, 32'(locked[0]), 32'(1));
        mode[0] = M_OV4;
        for (int i = 0; i < WINDOW; i++) begin
            step();
            if (i == 12) chk("ovl4_before", 0, 32'(err_overlap[0]), 32'(0));
            if (i == 13) begin
                chk("ovl4_flag", 0, 32'(err_overlap[0]), 32'(1));
                chk("ovl4_cnt", 0, 32'(err_cnt[0 +: ECW]), 32'(1));
            end
        end
        chk("ovl4_unlock", 0, 32'(locked[0]), 32'(0));
        chk("ovl4_lost", 0, 32'(lock_lost[0]), 32'(1));
        mode[0] = M_BAL;

        // Range saturation
        clr_err = 1'b1; step(); clr_err = 1'b0;
        chk("clr_cnt", 0, 32'(err_cnt[0 +: ECW]), 32'(0));
        chk("clr_ovl", 0, 32'(err_overlap[0]), 32'(0));
        set_code(0, 993);
        step();
        chk("range_flag", 0, 32'(err_range[0]), 32'(1));
        chk("range_cnt1", 0, 32'(err_cnt[0 +: ECW]), 32'(1));
        for (int i = 0; i < 300; i++) step();
        chk("range_sat", 0, 32'(err_cnt[0 +: ECW]), 32'(255));
        step();
        chk("range_sat_hold", 0, 32'(err_cnt[0 +: ECW]), 32'(255));
        set_code(0, 512);

        // X detection and clear collision
        clr_err = 1'b1; step(); clr_err = 1'b0;
        d[0] = 1'bx;
        step();
        chk("xz_flag", 0, 32'(err_xz[0]), 32'(sim4));
        d[0] = 1'b0; clr_err = 1'b1;
        step();
        chk("coll_err_d", 0, 32'(err_d[0]), 32'(1));
        chk("coll_cnt", 0, 32'(err_cnt[0 +: ECW]), 32'(1));
        chk("coll_xz", 0, 32'(err_xz[0]), 32'(0));
        d[0] = 1'b1; clr_err = 1'b0;

        // Random traffic
        for (int c = 0; c < N; c++) mode[c] = M_RND;
        for (int i = 0; i < 600; i++) begin
            for (int c = 0; c < N; c++) begin
                d[c] = ($urandom_range(0, 15) != 0);
                set_code(c, $urandom_range(0, 1023));
            end
            clr_err = ($urandom_range(0, 49) == 0);
            en = ($urandom_range(0, 99) != 0);
            step();
        end
        en = 1'b1; clr_err = 1'b0; d = '1;
        new_phases();
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < N; c++) set_code(c, $urandom_range(CODE_LO - 2, CODE_HI + 2));
            clr_err = ($urandom_range(0, 63) == 0);
            step();
        end
        clr_err = 1'b0;

        // Async reset while locked
        for (int c = 0; c < N; c++) set_code(c, 512);
        en = 1'b0; step(); en = 1'b1;
        new_phases();
        for (int i = 0; i < 4 * WINDOW; i++) step();
        chk("pre_rst_lock", 1, 32'(locked[1]), 32'(1));
        step();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("arst_locked", 1, 32'(locked), 32'(0));
        chk("arst_cnt", 1, 32'(err_cnt), 32'(0));
        chk("arst_flags", 1, 32'({err_d, err_range, err_overlap, err_xz, lock_lost}), 32'(0));
        check_all();
        @(negedge refclk);
        rst = 1'b0;
        for (int i = 0; i < 4 * WINDOW; i++) begin
            step();
            if (i == 4 * WINDOW - 2) chk("rst_relock_early", 1, 32'(locked[1]), 32'(0));
        end
        chk("rst_relock", 1, 32'(locked), 32'(2'b11));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pll_lock_monitor.md
# pll_lock_monitor

Parametrised, multi-channel lock and health monitor for the PFD/charge-pump path, clocked on the reference clock. Per channel it watches the PFD `up`/`down` pulses over fixed refclk windows and runs a lock-acquisition state machine. It also checks the divided-clock qualifier `d`, the digitised charge-pump output code, up/down overlap and X/Z on all inputs. Results are exposed as sticky error flags and saturating error counters. It is the synthesisable, N-channel generalisation of the per-PFD bind checker, and its outputs feed both the status CSRs and the bench scoreboards.

## Interface
- `N_CH`, 1: number of PFD/charge-pump channels
- `WINDOW`, 64: observation window length, in refclk cycles (≥ 4)
- `TOL`, 2: maximum |up_cnt − down_cnt| for a good window
- `LOCK_WINS`, 4: consecutive good windows required to declare lock
- `MAX_OVERLAP`, 3: longest legal run of cycles with up and down both high
- `CODE_W`, 10: width of the charge-pump code
- `CODE_LO`, 31: lowest legal code
- `CODE_HI`, 992: highest legal code
- `ERR_CNT_W`, 8: width of each error counter
- `refclk` in 1: sole clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `en` in 1: monitor enable
- `clr_err` in 1: synchronous clear of sticky flags and counters
- `d` in N_CH: qualifier, must be high while enabled
- `up`, `down` in N_CH each: PFD outputs, already sampled into the refclk domain
- `cp_code` in N_CH*CODE_W: charge-pump voltage code; channel i occupies bits [i*CODE_W +: CODE_W]
- `locked` out N_CH: lock status
- `lock_lost` out N_CH: one-cycle pulse on loss of lock
- `err_d`, `err_range`, `err_overlap`, `err_xz` out N_CH each: sticky error flags
- `err_cnt` out N_CH*ERR_CNT_W: per-channel error-event counters

## Operation
- **Window counter** (one, shared by all channels). Counts 0..WINDOW−1 while `en`=1. `win_end` is true when the count is WINDOW−1, then the counter wraps to 0. When `en`=0 the counter holds at 0.
- **Per-channel counters.** `up_cnt` and `down_cnt` are $clog2(WINDOW+1) bits wide. Each increments on cycles where its input is 1. The sample taken in the `win_end` cycle is included. Both counters clear for the next window.
- **Good window.** A window is good when |up_cnt − down_cnt| ≤ TOL and no overlap violation occurred in it. Use an unsigned difference; no wrap is possible.
- **FSM per channel:** IDLE, ACQ, LOCKED.
  - IDLE → ACQ when `en`=1, with `good_wins`=0.
  - ACQ, at `win_end`: on a good window increment `good_wins`, and move to LOCKED when it reaches LOCK_WINS. On a bad window set `good_wins`=0.
  - LOCKED, at `win_end` with a bad window: go to ACQ, set `good_wins`=0, pulse `lock_lost` for 1 cycle.
  - Any state → IDLE when `en`=0. This clears the window counters, clears `locked` and does not pulse `lock_lost`.
- **`locked`** is 1 exactly while the FSM is in LOCKED.
- **Error conditions** are evaluated each cycle and only while `en`=1:
  - d-condition: d=0.
  - range-condition: cp_code < CODE_LO or cp_code > CODE_HI.
  - overlap-condition: the run of cycles with up&down=1 reaches MAX_OVERLAP+1. It re-fires on each further cycle of the run.
  - xz-condition: $isunknown on that channel's d/up/down/cp_code. Unknown bits count as 0 for the window counters.
- **Error flags** are sticky: each flag sets on its condition and clears only on `clr_err` or `rst`.
- **`err_cnt`** increments by 1 on every cycle in which any condition fires, and saturates at all-ones.
- **Clear vs new event.** If `clr_err` coincides with a condition, the condition wins: the flag is 1 and `err_cnt` is 1.

## Timing
- All outputs are registered.
- A condition sampled at edge n is visible on the flag and counter after edge n.
- `locked` rises on the edge that samples the `win_end` of the LOCK_WINS-th consecutive good window.
- `lock_lost` is high for exactly one cycle, coincident with `locked` falling.
- Reset values: `locked`, `lock_lost`, all flags and all `err_cnt` are 0; FSM is IDLE; window counter is 0.
- `rst` mid-operation clears everything immediately, without a clock edge.
- Deasserting `en` freezes flags and counters. Reasserting it starts a fresh window from count 0.

## Structure
- Package `pll_mon_pkg` holds the `mon_state_t` enum (IDLE/ACQ/LOCKED) and the `abs_diff` function.
- Sub-module `pll_mon_chan` contains one channel's window counters, FSM, overlap run counter and error logic.
- The top level instantiates N_CH copies of `pll_mon_chan` with a generate loop and owns the shared window counter.

## Test plan
- **Balanced lock.** Defaults, en=1 from cycle 0, up and down each 1 cycle in every 8, d=1, cp_code=512 → `locked`=1 after edge 256; no flags; err_cnt=0.
- **Imbalance after lock.** up 10 and down 2 per window → at the next `win_end`, `locked`=0 and `lock_lost` is high for one cycle. Restoring balance gives `locked`=1 again after 4 more windows.
- **Overlap boundary.** up=down=1 for 3 cycles → no error. For 4 cycles → `err_overlap`=1 and err_cnt=1; that window is bad.
- **Range saturation.** cp_code=993 for 1 cycle → `err_range`=1 and err_cnt=1. Holding 993 for 300 cycles → err_cnt=255 and it stays there.
- **Clear collision and X detection.** d=X for 1 cycle → `err_xz`=1. `clr_err` in the same cycle as d=0 → `err_d`=1 and err_cnt=1; `err_xz` cleared.
- **Async reset while locked.** N_CH=2, with channel 1 locked → asserting `rst` between edges drives all outputs to 0 immediately; after release, lock re-acquires after 4 windows.
